// File: rtl/conv_layer_sched.sv
// conv_layer_sched
//   Single-layer scheduler for one CONV instance. On a start request it
//   pulses start_conv, then serves CONV's IFM and weight read strobes from
//   the on-chip SRAMs (1-cycle read latency) and writes every CONV result
//   into the OFM buffer. Reports done (and err on a short layer, an OFM
//   overflow or a watchdog timeout) when the layer ends.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for start; counters hold their last values
//   LAUNCH | start_conv pulse to CONV (one cycle)
//   RUN    | serving ifm_read / wgt_read / out_valid, watchdog armed
//   FINISH | end_conv seen; done pulse (one cycle)
//   FAULT  | watchdog expired; err set, done pulse (one cycle)
//
// Ports
//   clk1, rst                  clock, synchronous active-high reset
//   start / busy / done / err  layer-controller handshake
//   start_conv, ifm_read, wgt_read, out_valid, end_conv, data_output,
//   ifm, wgt                   CONV side
//   ifm_mem_*, wgt_mem_*       IFM / weight SRAM read ports
//   ofm_we, ofm_addr, ofm_wdata  OFM buffer write port
module conv_layer_sched #(
    parameter int DATA_WIDTH   = 16,
    parameter int IFM_WIDTH    = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int IFM_SIZE     = 64,
    parameter int KERNEL_SIZE  = 3,
    parameter int STRIDE       = 1,
    parameter int PAD          = 0,
    parameter int CI           = 3,
    parameter int CO           = 8,
    parameter int ADDR_W       = 16,
    parameter int TIMEOUT      = 4096
) (
    input  logic                    clk1,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    start_conv,
    input  logic                    ifm_read,
    input  logic                    wgt_read,
    input  logic                    out_valid,
    input  logic                    end_conv,
    input  logic [DATA_WIDTH-1:0]   data_output,
    output logic [IFM_WIDTH-1:0]    ifm,
    output logic [WEIGHT_WIDTH-1:0] wgt,
    output logic                    ifm_mem_en,
    output logic [ADDR_W-1:0]       ifm_mem_addr,
    input  logic [IFM_WIDTH-1:0]    ifm_mem_rdata,
    output logic                    wgt_mem_en,
    output logic [ADDR_W-1:0]       wgt_mem_addr,
    input  logic [WEIGHT_WIDTH-1:0] wgt_mem_rdata,
    output logic                    ofm_we,
    output logic [ADDR_W-1:0]       ofm_addr,
    output logic [DATA_WIDTH-1:0]   ofm_wdata
);

    localparam int IFM_WORDS = CI * IFM_SIZE * IFM_SIZE;
    localparam int WGT_WORDS = CO * CI * KERNEL_SIZE * KERNEL_SIZE;
    localparam int OFM_SIZE  = (IFM_SIZE + 2 * PAD - KERNEL_SIZE) / STRIDE + 1;
    localparam int OFM_WORDS = OFM_SIZE * OFM_SIZE * CO;
    localparam int WDOG_W    = $clog2(TIMEOUT);

    localparam logic [ADDR_W-1:0] IFM_LAST  = ADDR_W'(IFM_WORDS - 1);
    localparam logic [ADDR_W-1:0] WGT_LAST  = ADDR_W'(WGT_WORDS - 1);
    localparam logic [ADDR_W-1:0] OFM_TOTAL = ADDR_W'(OFM_WORDS);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_FINISH,
        S_FAULT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ifm_cnt_q, ifm_cnt_d;
    logic [ADDR_W-1:0]   wgt_cnt_q, wgt_cnt_d;
    logic [ADDR_W-1:0]   ofm_cnt_q, ofm_cnt_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                ifm_vld_q, ifm_vld_d;
    logic                wgt_vld_q, wgt_vld_d;
    logic                err_q, err_d;

    logic run, accept, ifm_hit, wgt_hit, ofm_hit, ofm_ovf;

    // Strobes only act in RUN; outside it they are dropped entirely.
    assign run     = (state_q == S_RUN);
    assign accept  = (state_q == S_IDLE) && start;
    assign ifm_hit = run && ifm_read;
    assign wgt_hit = run && wgt_read;
    assign ofm_hit = run && out_valid && (ofm_cnt_q < OFM_TOTAL);
    assign ofm_ovf = run && out_valid && (ofm_cnt_q >= OFM_TOTAL);

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ifm_cnt_q <= '0;
            wgt_cnt_q <= '0;
            ofm_cnt_q <= '0;
            wdog_q    <= '0;
            ifm_vld_q <= 1'b0;
            wgt_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ifm_cnt_q <= ifm_cnt_d;
            wgt_cnt_q <= wgt_cnt_d;
            ofm_cnt_q <= ofm_cnt_d;
            wdog_q    <= wdog_d;
            ifm_vld_q <= ifm_vld_d;
            wgt_vld_q <= wgt_vld_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_RUN;
            S_RUN: begin
                if (end_conv)                state_d = S_FINISH;
                else if (wdog_q == WDOG_LAST) state_d = S_FAULT;
            end
            S_FINISH: state_d = S_IDLE;
            S_FAULT:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ifm_cnt_d = ifm_cnt_q;
        wgt_cnt_d = wgt_cnt_q;
        ofm_cnt_d = ofm_cnt_q;
        wdog_d    = wdog_q;
        ifm_vld_d = ifm_hit;
        wgt_vld_d = wgt_hit;
        err_d     = err_q;

        if (accept) begin
            ifm_cnt_d = '0;
            wgt_cnt_d = '0;
            ofm_cnt_d = '0;
            wdog_d    = '0;
            err_d     = 1'b0;
        end

        // IFM and weight address counters wrap so CONV can re-stream them.
        if (ifm_hit) ifm_cnt_d = (ifm_cnt_q == IFM_LAST) ? '0 : ifm_cnt_q + 1'b1;
        if (wgt_hit) wgt_cnt_d = (wgt_cnt_q == WGT_LAST) ? '0 : wgt_cnt_q + 1'b1;
        if (ofm_hit) ofm_cnt_d = ofm_cnt_q + 1'b1;
        if (ofm_ovf) err_d = 1'b1;

        if (run) begin
            if (ifm_read || wgt_read || out_valid) wdog_d = '0;
            else                                   wdog_d = wdog_q + 1'b1;
        end

        // Uses ofm_cnt_d so an out_valid in the end_conv cycle is counted.
        if (run && end_conv && (ofm_cnt_d != OFM_TOTAL)) err_d = 1'b1;
        if (run && (state_d == S_FAULT))                 err_d = 1'b1;
    end

    always_comb begin
        busy         = (state_q != S_IDLE);
        done         = (state_q == S_FINISH) || (state_q == S_FAULT);
        start_conv   = (state_q == S_LAUNCH);
        err          = err_q;
        ifm_mem_en   = ifm_hit;
        ifm_mem_addr = ifm_cnt_q;
        wgt_mem_en   = wgt_hit;
        wgt_mem_addr = wgt_cnt_q;
        ifm          = ifm_vld_q ? ifm_mem_rdata : '0;
        wgt          = wgt_vld_q ? wgt_mem_rdata : '0;
        ofm_we       = ofm_hit;
        ofm_addr     = ofm_hit ? ofm_cnt_q : '0;
        ofm_wdata    = ofm_hit ? data_output : '0;
    end

endmodule

// File: tb/tb_conv_layer_sched.sv
module tb_conv_layer_sched;

    localparam int IFM_WORDS = 12288;
    localparam int WGT_WORDS = 216;
    localparam int OFM_WORDS = 30752;

    logic        clk1 = 1'b0;
    logic        rst, start;
    logic        busy, done, err, start_conv;
    logic        ifm_read, wgt_read, out_valid, end_conv;
    logic [15:0] data_output;
    logic [7:0]  ifm, wgt;
    logic        ifm_mem_en, wgt_mem_en, ofm_we;
    logic [15:0] ifm_mem_addr, wgt_mem_addr, ofm_addr, ofm_wdata;
    logic [7:0]  ifm_mem_rdata = 8'h00;
    logic [7:0]  wgt_mem_rdata = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int sc_cnt = 0;
    int wr_cnt = 0;
    logic [15:0] ofm_mem [0:OFM_WORDS-1];

    always #5 clk1 = ~clk1;

    conv_layer_sched dut (
        .clk1(clk1), .rst(rst), .start(start), .busy(busy), .done(done),
        .err(err), .start_conv(start_conv), .ifm_read(ifm_read),
        .wgt_read(wgt_read), .out_valid(out_valid), .end_conv(end_conv),
        .data_output(data_output), .ifm(ifm), .wgt(wgt),
        .ifm_mem_en(ifm_mem_en), .ifm_mem_addr(ifm_mem_addr),
        .ifm_mem_rdata(ifm_mem_rdata), .wgt_mem_en(wgt_mem_en),
        .wgt_mem_addr(wgt_mem_addr), .wgt_mem_rdata(wgt_mem_rdata),
        .ofm_we(ofm_we), .ofm_addr(ofm_addr), .ofm_wdata(ofm_wdata)
    );

    function automatic logic [7:0] f_ifm(input logic [15:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction
    function automatic logic [7:0] f_wgt(input logic [15:0] a);
        return a[7:0] + 8'h33;
    endfunction
    function automatic logic [15:0] f_ofm(input int i);
        return 16'(i * 37 + 5);
    endfunction

    // SRAM models with 1-cycle read latency, OFM buffer and event counters.
    always @(posedge clk1) begin
        if (ifm_mem_en) ifm_mem_rdata <= f_ifm(ifm_mem_addr);
        if (wgt_mem_en) wgt_mem_rdata <= f_wgt(wgt_mem_addr);
        if (ofm_we) begin
            ofm_mem[ofm_addr] <= ofm_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (done)       done_cnt <= done_cnt + 1;
        if (start_conv) sc_cnt   <= sc_cnt + 1;
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic clear_strobes();
        ifm_read = 0; wgt_read = 0; out_valid = 0; end_conv = 0; data_output = '0;
    endtask

    // Leaves the DUT in LAUNCH; the caller's next step() drives the first RUN cycle.
    task automatic start_layer(input string nm);
        step();
        start = 1;
        @(negedge clk1);
        step();
        start = 0;
        @(negedge clk1);
        check({nm, "_launch"}, {start_conv, busy, err}, 3'b110);
    endtask

    typedef struct {
        logic        ir, wr, ov;
        logic [15:0] dout;
        logic        e_ifm_en;
        logic [15:0] e_ifm_addr;
        logic [7:0]  e_ifm;
        logic        e_wgt_en;
        logic [15:0] e_wgt_addr;
        logic [7:0]  e_wgt;
        logic        e_we;
        logic [15:0] e_oaddr, e_wdata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int sc0, d0, w0, bad_a, bad_d, got;
        vecs[0] = '{1, 0, 0, 16'h0000, 1, 16'd0, 8'h00, 0, 16'd0, 8'h00, 0, 16'd0, 16'h0000};
        vecs[1] = '{1, 1, 0, 16'h0000, 1, 16'd1, 8'h5A, 1, 16'd0, 8'h00, 0, 16'd0, 16'h0000};
        vecs[2] = '{0, 0, 1, 16'hBEEF, 0, 16'd2, 8'h5B, 0, 16'd1, 8'h33, 1, 16'd0, 16'hBEEF};
        vecs[3] = '{0, 0, 0, 16'h7777, 0, 16'd2, 8'h00, 0, 16'd1, 8'h00, 0, 16'd0, 16'h0000};
        vecs[4] = '{0, 1, 1, 16'h1234, 0, 16'd2, 8'h00, 1, 16'd1, 8'h00, 1, 16'd1, 16'h1234};
        vecs[5] = '{1, 0, 0, 16'h0000, 1, 16'd2, 8'h00, 0, 16'd2, 8'h34, 0, 16'd0, 16'h0000};
        vecs[6] = '{1, 0, 1, 16'h0042, 1, 16'd3, 8'h58, 0, 16'd2, 8'h00, 1, 16'd2, 16'h0042};
        vecs[7] = '{0, 0, 0, 16'h0000, 0, 16'd4, 8'h59, 0, 16'd2, 8'h00, 0, 16'd0, 16'h0000};

        // Reset held with start asserted: everything stays quiet.
        rst = 1; start = 1;
        clear_strobes();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk1);
            check("reset_outputs",
                  {busy, done, err, start_conv, ifm, wgt, ifm_mem_en, ifm_mem_addr,
                   wgt_mem_en, wgt_mem_addr, ofm_we, ofm_addr, ofm_wdata}, '0);
        end
        step();
        rst = 0; start = 0;
        @(negedge clk1);
        check("reset_no_start_conv", 32'(sc_cnt), 0);

        // Directed single-cycle vectors in RUN.
        start_layer("vec");
        foreach (vecs[k]) begin
            step();
            ifm_read = vecs[k].ir; wgt_read = vecs[k].wr;
            out_valid = vecs[k].ov; data_output = vecs[k].dout;
            @(negedge clk1);
            check($sformatf("vec%0d", k),
                  {busy, ifm_mem_en, ifm_mem_addr, ifm, wgt_mem_en, wgt_mem_addr, wgt,
                   ofm_we, ofm_addr, ofm_wdata},
                  {1'b1, vecs[k].e_ifm_en, vecs[k].e_ifm_addr, vecs[k].e_ifm,
                   vecs[k].e_wgt_en, vecs[k].e_wgt_addr, vecs[k].e_wgt,
                   vecs[k].e_we, vecs[k].e_oaddr, vecs[k].e_wdata});
        end

        // start during RUN is ignored.
        for (int c = 0; c < 3; c++) begin
            step();
            clear_strobes();
            start = 1;
            @(negedge clk1);
        end
        start = 0;
        check("no_second_start_conv", 32'(sc_cnt), 1);
        step(); end_conv = 1;
        step(); end_conv = 0;
        @(negedge clk1);
        check("vec_finish_short", {done, err, busy}, 3'b111);
        step();
        @(negedge clk1);
        check("vec_idle", {done, busy, err}, 3'b001);

        // Strobes outside RUN are dropped.
        step(); ifm_read = 1; wgt_read = 1; out_valid = 1; data_output = 16'hAAAA;
        @(negedge clk1);
        check("idle_strobes_ignored", {ifm_mem_en, wgt_mem_en, ofm_we, ofm_addr}, '0);
        step(); clear_strobes();
        @(negedge clk1);
        check("idle_no_valid", {ifm, wgt}, '0);

        // Nominal layer; end_conv coincides with the last out_valid.
        d0 = done_cnt; w0 = wr_cnt; bad_a = 0; bad_d = 0;
        start_layer("nom");
        for (int i = 0; i < OFM_WORDS; i++) begin
            step();
            ifm_read = (i < IFM_WORDS); wgt_read = (i < WGT_WORDS);
            out_valid = 1; data_output = f_ofm(i); end_conv = (i == OFM_WORDS - 1);
            @(negedge clk1);
            if (ifm_read && ifm_mem_addr != 16'(i)) bad_a++;
            if (wgt_read && wgt_mem_addr != 16'(i)) bad_a++;
            if (ofm_addr != 16'(i) || !ofm_we) bad_a++;
            if (i > 0 && i <= IFM_WORDS && ifm != f_ifm(16'(i - 1))) bad_d++;
            if (i > 0 && i <= WGT_WORDS && wgt != f_wgt(16'(i - 1))) bad_d++;
        end
        check("nom_addr_errors", 32'(bad_a), 0);
        check("nom_data_errors", 32'(bad_d), 0);
        step(); clear_strobes();
        @(negedge clk1);
        check("nom_finish", {done, err, busy}, 3'b101);
        step();
        @(negedge clk1);
        check("nom_idle", {done, busy, err}, 3'b000);
        check("nom_done_pulses", 32'(done_cnt - d0), 1);
        check("nom_write_count", 32'(wr_cnt - w0), 32'(OFM_WORDS));
        bad_d = 0;
        for (int i = 0; i < OFM_WORDS; i++)
            if (ofm_mem[i] !== f_ofm(i)) bad_d++;
        check("nom_ofm_contents", 32'(bad_d), 0);

        // Short layer with IFM / weight address wrap.
        bad_a = 0;
        start_layer("short");
        for (int i = 0; i < OFM_WORDS - 1; i++) begin
            step();
            ifm_read = (i < IFM_WORDS + 2); wgt_read = (i < WGT_WORDS + 2);
            out_valid = 1; data_output = f_ofm(i);
            @(negedge clk1);
            if (ifm_read && ifm_mem_addr != 16'(i % IFM_WORDS)) bad_a++;
            if (wgt_read && wgt_mem_addr != 16'(i % WGT_WORDS)) bad_a++;
            if (i == IFM_WORDS - 1) check("wrap_addr_last", ifm_mem_addr, 16'd12287);
            if (i == IFM_WORDS) begin
                check("wrap_data_last", ifm, 8'hA5);
                check("wrap_addr_zero", ifm_mem_addr, 16'd0);
            end
            if (i == WGT_WORDS) check("wgt_wrap_addr_zero", wgt_mem_addr, 16'd0);
        end
        check("short_addr_errors", 32'(bad_a), 0);
        step(); clear_strobes(); end_conv = 1;
        step(); end_conv = 0;
        @(negedge clk1);
        check("short_finish", {done, err}, 2'b11);

        // Watchdog stall: 4096 silent RUN cycles then FAULT.
        start_layer("stall");
        got = 0;
        for (int c = 1; c <= 5000; c++) begin
            step();
            @(negedge clk1);
            if (done) begin
                got = c;
                break;
            end
        end
        check("stall_fault_cycle", 32'(got), 4097);
        check("stall_fault_flags", {done, err, busy}, 3'b111);
        step();
        @(negedge clk1);
        check("stall_idle", {busy, done, err}, 3'b001);

        // Reset mid-layer aborts without a done pulse.
        start_layer("abort");
        step(); out_valid = 1; data_output = 16'h1111;
        step(); rst = 1;
        step();
        @(negedge clk1);
        check("abort_idle", {busy, ofm_we, done, err, start_conv}, '0);
        d0 = done_cnt;
        step(); rst = 0; clear_strobes();
        for (int c = 0; c < 5; c++) step();
        @(negedge clk1);
        check("abort_no_done", 32'(done_cnt - d0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
